// File: rtl/vram_model_pkg.sv
// Shared types and constants for the clocked video-RAM model.
// FSM state encoding, error counter sizing and counter width helper.
package vram_model_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_VALID,
        WR_ACC,
        WR_DONE
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int m;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/vram_access_timer.sv
// Latched access address plus restart/increment cycle counter.
// Shared by the read and write paths of the video-RAM model.
module vram_access_timer
    import vram_model_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  cnt
);

    // Load restarts the count at 1 on a new address; inc extends it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= addr_in;
            cnt  <= CNT_W'(1);
        end else if (inc) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vram_sync_model.sv
// Clocked behavioural model of the slow video RAM.
// Cycle-quantised read latency, strobe-width writes, overlap counter.
module vram_sync_model
    import vram_model_pkg::*;
#(
    parameter int    ADDR_W    = 15,
    parameter int    DATA_W    = 8,
    parameter int    RD_LAT    = 3,
    parameter int    WR_LAT    = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                 CLK_24M,
    input  logic                 nRESET,
    input  logic [ADDR_W-1:0]    ADDR,
    inout  wire  [DATA_W-1:0]    DATA,
    input  logic                 nCE,
    input  logic                 nOE,
    input  logic                 nWE,
    output logic                 RDY,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int CNT_W = cnt_width(RD_LAT, WR_LAT);
    localparam logic [CNT_W-1:0] RD_N = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_N = CNT_W'(WR_LAT);
    localparam bit RD_ONE = (RD_LAT == 1);
    localparam bit WR_ONE = (WR_LAT == 1);

    state_t state;
    state_t state_n;
    state_t st_rd;
    state_t st_wr;

    logic              wr;
    logic              rd;
    logic              same;
    logic              load;
    logic              inc;
    logic              commit;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i] = '0;
        end
    end

    assign wr      = !nCE && !nWE;
    assign rd      = !nCE && !nOE && nWE;
    assign same    = (ADDR == lat_addr);
    assign cnt_inc = cnt + CNT_W'(1);
    assign wr_addr = load ? ADDR : lat_addr;
    assign st_rd   = RD_ONE ? RD_VALID : RD_ACC;
    assign st_wr   = WR_ONE ? WR_DONE : WR_ACC;

    vram_access_timer #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk     (CLK_24M),
        .rst_n   (nRESET),
        .load    (load),
        .inc     (inc),
        .addr_in (ADDR),
        .addr    (lat_addr),
        .cnt     (cnt)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        inc     = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr) begin
                    load    = 1'b1;
                    commit  = WR_ONE;
                    state_n = st_wr;
                end else if (rd) begin
                    load    = 1'b1;
                    state_n = st_rd;
                end
            end
            RD_ACC: begin
                if (wr) begin
                    load    = 1'b1;
                    commit  = WR_ONE;
                    state_n = st_wr;
                end else if (rd && same) begin
                    inc = 1'b1;
                    if (cnt_inc == RD_N) state_n = RD_VALID;
                end else if (rd) begin
                    load    = 1'b1;
                    state_n = st_rd;
                end else begin
                    state_n = IDLE;
                end
            end
            RD_VALID: begin
                if (wr) begin
                    load    = 1'b1;
                    commit  = WR_ONE;
                    state_n = st_wr;
                end else if (rd && !same) begin
                    load    = 1'b1;
                    state_n = st_rd;
                end else if (!rd) begin
                    state_n = IDLE;
                end
            end
            WR_ACC: begin
                if (wr && same) begin
                    inc = 1'b1;
                    if (cnt_inc == WR_N) begin
                        commit  = 1'b1;
                        state_n = WR_DONE;
                    end
                end else if (wr) begin
                    load    = 1'b1;
                    commit  = WR_ONE;
                    state_n = st_wr;
                end else begin
                    state_n = IDLE;
                end
            end
            WR_DONE: begin
                if (!wr) begin
                    if (rd) begin
                        load    = 1'b1;
                        state_n = st_rd;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            state <= IDLE;
            RDY   <= 1'b0;
        end else begin
            state <= state_n;
            RDY   <= (state_n == RD_VALID);
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (nRESET && commit) begin
            mem[wr_addr] <= DATA;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            ERR     <= 1'b0;
            ERR_CNT <= '0;
        end else if (!nOE && !nWE) begin
            ERR <= 1'b1;
            if (ERR_CNT != ERR_CNT_MAX) begin
                ERR_CNT <= ERR_CNT + 1'b1;
            end
        end
    end

    assign rd_data = RDY ? mem[lat_addr] : {DATA_W{1'bx}};
    assign DATA    = rd ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_vram_sync_model.sv
// Directed bench for vram_sync_model.
// Two instances share the bus controls: WR_LAT=1 and WR_LAT=2.
module tb_vram_sync_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        drv;

    wire  [7:0]  data1;
    wire  [7:0]  data2;
    logic        rdy1;
    logic        rdy2;
    logic        err1;
    logic        err2;
    logic [7:0]  ecnt1;
    logic [7:0]  ecnt2;

    int n_chk  = 0;
    int n_fail = 0;

    always #21 clk = ~clk;

    assign data1 = drv ? wdata : 8'hzz;
    assign data2 = drv ? wdata : 8'hzz;

    vram_sync_model #(
        .ADDR_W (15),
        .DATA_W (8),
        .RD_LAT (3),
        .WR_LAT (1)
    ) u_dut1 (
        .CLK_24M (clk),
        .nRESET  (rst_n),
        .ADDR    (addr),
        .DATA    (data1),
        .nCE     (ce_n),
        .nOE     (oe_n),
        .nWE     (we_n),
        .RDY     (rdy1),
        .ERR     (err1),
        .ERR_CNT (ecnt1)
    );

    vram_sync_model #(
        .ADDR_W (15),
        .DATA_W (8),
        .RD_LAT (3),
        .WR_LAT (2)
    ) u_dut2 (
        .CLK_24M (clk),
        .nRESET  (rst_n),
        .ADDR    (addr),
        .DATA    (data2),
        .nCE     (ce_n),
        .nOE     (oe_n),
        .nWE     (we_n),
        .RDY     (rdy2),
        .ERR     (err2),
        .ERR_CNT (ecnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_n = 1'b1;
        oe_n = 1'b1;
        we_n = 1'b1;
        drv  = 1'b0;
    endtask

    task automatic wr_op(input logic [14:0] a, input logic [7:0] d,
                         input int n);
        addr  = a;
        wdata = d;
        drv   = 1'b1;
        ce_n  = 1'b0;
        oe_n  = 1'b1;
        we_n  = 1'b0;
        repeat (n) tick();
        idle();
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [14:0] a,
                          input logic [7:0] e1, input logic [7:0] e2,
                          input bit c2);
        addr = a;
        drv  = 1'b0;
        ce_n = 1'b0;
        oe_n = 1'b0;
        we_n = 1'b1;
        tick();
        chk({tag, "_rdy_e1"}, 32'(rdy1), 32'd0);
        tick();
        chk({tag, "_rdy_e2"}, 32'(rdy1), 32'd0);
        tick();
        chk({tag, "_rdy_e3"}, 32'(rdy1), 32'd1);
        chk({tag, "_data1"}, 32'(data1), 32'(e1));
        if (c2) begin
            chk({tag, "_rdy2"}, 32'(rdy2), 32'd1);
            chk({tag, "_data2"}, 32'(data2), 32'(e2));
        end
        idle();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        idle();
        tick();
        tick();
        chk("rst_rdy", 32'(rdy1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_cnt", 32'(ecnt1), 32'd0);
        rst_n = 1'b1;
        tick();

        wr_op(15'h0010, 8'hA5, 1);
        rd_chk("rd_0010", 15'h0010, 8'hA5, 8'h00, 1'b0);

        wr_op(15'h7FFF, 8'h3C, 1);
        wr_op(15'h0000, 8'h5A, 1);
        rd_chk("rd_7fff", 15'h7FFF, 8'h3C, 8'h00, 1'b0);
        rd_chk("rd_0000", 15'h0000, 8'h5A, 8'h00, 1'b0);

        wr_op(15'h0100, 8'h11, 3);
        wr_op(15'h0100, 8'h22, 1);
        rd_chk("wrlat_abort", 15'h0100, 8'h22, 8'h11, 1'b1);
        wr_op(15'h0100, 8'h33, 3);
        rd_chk("wrlat_commit", 15'h0100, 8'h33, 8'h33, 1'b1);

        wr_op(15'h0001, 8'h61, 1);
        wr_op(15'h0002, 8'h62, 1);
        addr = 15'h0001;
        ce_n = 1'b0;
        oe_n = 1'b0;
        we_n = 1'b1;
        tick();
        chk("achg_e1", 32'(rdy1), 32'd0);
        tick();
        chk("achg_e2", 32'(rdy1), 32'd0);
        addr = 15'h0002;
        tick();
        chk("achg_e3", 32'(rdy1), 32'd0);
        tick();
        chk("achg_e4", 32'(rdy1), 32'd0);
        tick();
        chk("achg_e5", 32'(rdy1), 32'd1);
        chk("achg_data", 32'(data1), 32'h62);
        idle();
        tick();

        chk("ovl_pre_err", 32'(err1), 32'd0);
        addr  = 15'h0200;
        wdata = 8'h77;
        drv   = 1'b1;
        ce_n  = 1'b0;
        oe_n  = 1'b0;
        we_n  = 1'b0;
        tick();
        chk("ovl_err1", 32'(err1), 32'd1);
        chk("ovl_cnt1", 32'(ecnt1), 32'd1);
        repeat (254) tick();
        chk("ovl_cnt255", 32'(ecnt1), 32'd255);
        repeat (45) tick();
        chk("ovl_sat", 32'(ecnt1), 32'd255);
        chk("ovl_sat2", 32'(ecnt2), 32'd255);
        idle();
        tick();
        chk("ovl_sticky", 32'(err1), 32'd1);
        rd_chk("ovl_wr", 15'h0200, 8'h77, 8'h77, 1'b1);

        addr = 15'h7FFF;
        ce_n = 1'b0;
        oe_n = 1'b0;
        we_n = 1'b1;
        repeat (3) tick();
        chk("rstrd_pre", 32'(rdy1), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstrd_rdy", 32'(rdy1), 32'd0);
        chk("rstrd_err", 32'(err1), 32'd0);
        chk("rstrd_cnt", 32'(ecnt1), 32'd0);
        rst_n = 1'b1;
        idle();
        tick();

        rst_n = 1'b0;
        addr  = 15'h0010;
        wdata = 8'h99;
        drv   = 1'b1;
        ce_n  = 1'b0;
        we_n  = 1'b0;
        tick();
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        rd_chk("rstwr_keep", 15'h0010, 8'hA5, 8'h00, 1'b0);

        addr  = 15'h0100;
        wdata = 8'h44;
        drv   = 1'b1;
        ce_n  = 1'b0;
        we_n  = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstwr_err2", 32'(err2), 32'd0);
        chk("rstwr_cnt2", 32'(ecnt2), 32'd0);
        idle();
        rst_n = 1'b1;
        tick();
        rd_chk("rstwr_mid", 15'h0100, 8'h44, 8'h33, 1'b1);
        rd_chk("rst_intact", 15'h7FFF, 8'h3C, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
